// File: rtl/register16_univ_shift.sv
// +--------------------------------------------------------------------------+
// | register16_univ_shift                                                    |
// | WIDTH-bit universal register: load/clear/hold, 1-bit shift/rotate steps, |
// | and a shift-by-N sequencer with busy/done. Optional macro: REG_PARITY_EN |
// | (adds q_par, registered even parity of q).                               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module register16_univ_shift #(
  parameter int unsigned          WIDTH     = 16,
  parameter int unsigned          SHW       = 5,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic [SHW-1:0]   shamt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef REG_PARITY_EN
  ,
  output logic             q_par
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] C_HOLD  = 3'b000;
  localparam logic [2:0] C_LOAD  = 3'b001;
  localparam logic [2:0] C_SLL   = 3'b010;
  localparam logic [2:0] C_SRL   = 3'b011;
  localparam logic [2:0] C_SRA   = 3'b100;
  localparam logic [2:0] C_ROL   = 3'b101;
  localparam logic [2:0] C_ROR   = 3'b110;
  localparam logic [2:0] C_CLEAR = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [2:0]       mode_lat_q, mode_lat_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_val;
  logic             step_ser;
  logic             is_shift;

  // In SHIFT the latched mode drives the step; live mode is ignored.
  assign step_mode = (state_q == SHIFT) ? mode_lat_q : mode;
  assign is_shift  = (mode != C_HOLD) && (mode != C_LOAD) && (mode != C_CLEAR);

  always_comb begin
    step_val = reg_q;
    step_ser = ser_q;
    case (step_mode)
      C_LOAD:  step_val = d;
      C_SLL: begin
        step_val = {reg_q[WIDTH-2:0], ser_in};
        step_ser = reg_q[WIDTH-1];
      end
      C_SRL: begin
        step_val = {ser_in, reg_q[WIDTH-1:1]};
        step_ser = reg_q[0];
      end
      C_SRA: begin
        step_val = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
        step_ser = reg_q[0];
      end
      C_ROL: begin
        step_val = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
        step_ser = reg_q[WIDTH-1];
      end
      C_ROR: begin
        step_val = {reg_q[0], reg_q[WIDTH-1:1]};
        step_ser = reg_q[0];
      end
      C_CLEAR: step_val = '0;
      default: step_val = reg_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    reg_d      = reg_q;
    ser_d      = ser_q;
    done_d     = 1'b0;
    rem_d      = rem_q;
    mode_lat_d = mode_lat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!is_shift) begin
            reg_d  = step_val;
            done_d = 1'b1;
          end else if (shamt == '0) begin
            done_d = 1'b1;
          end else begin
            reg_d = step_val;
            ser_d = step_ser;
            if (shamt == SHW'(1)) begin
              done_d = 1'b1;
            end else begin
              state_d    = SHIFT;
              rem_d      = shamt - SHW'(1);
              mode_lat_d = mode;
            end
          end
        end else if (en) begin
          reg_d = step_val;
          if (is_shift) ser_d = step_ser;
        end
      end
      SHIFT: begin
        reg_d = step_val;
        ser_d = step_ser;
        rem_d = rem_q - SHW'(1);
        if (rem_q == SHW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      reg_q      <= RESET_VAL;
      ser_q      <= 1'b0;
      done_q     <= 1'b0;
      rem_q      <= '0;
      mode_lat_q <= C_HOLD;
    end else begin
      state_q    <= state_d;
      reg_q      <= reg_d;
      ser_q      <= ser_d;
      done_q     <= done_d;
      rem_q      <= rem_d;
      mode_lat_q <= mode_lat_d;
    end
  end

  assign q       = reg_q;
  assign ser_out = ser_q;
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;

`ifdef REG_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= ^RESET_VAL;
    else       par_q <= ^reg_d;
  end

  assign q_par = par_q;
`endif

endmodule

`default_nettype wire
